// File: rtl/hms_countdown.sv
// rtl/hms_countdown.sv - 24-hour HH:MM:SS BCD countdown timer with validated preset load
//
// Optional feature macro: HMS_COUNTDOWN_AUTO_RELOAD_EN
//   When defined, the expiry tick reloads the stored preset and the timer keeps running.
//
// Digit order on the output bus: sec0 = seconds units ... sec5 = hours tens.
// Internally the count is held as one 24-bit BCD word laid out like `preset`.

module hms_countdown #(
    parameter int TICK_POL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        load,
    input  logic [23:0] preset,
    input  logic        start,
    input  logic        pause,
    output logic [3:0]  sec0,
    output logic [3:0]  sec1,
    output logic [3:0]  sec2,
    output logic [3:0]  sec3,
    output logic [3:0]  sec4,
    output logic [3:0]  sec5,
    output logic        running,
    output logic        done,
    output logic        load_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Count value one second before expiry.
    localparam logic [23:0] COUNT_ONE  = 24'h000001;
    localparam logic [23:0] COUNT_ZERO = 24'h000000;

    // Value each digit wraps to when it borrows. The hours-tens entry is
    // never used: a nonzero count never borrows out of the top digit.
    localparam logic [23:0] WRAP_DIGITS = 24'h095959;

    state_t      state_q, state_d;
    logic [23:0] count_q, count_d;
    logic        running_q, running_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
    // Last accepted preset, reloaded on each expiry.
    logic [23:0] preset_q, preset_d;
`endif

    logic        tick_act;
    logic        preset_ok;
    logic [23:0] count_dec;

    // Checks that a BCD word is a legal 24-hour time of day.
    function automatic logic bcd_time_valid(input logic [23:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        if (v[7:4] > 4'd5) begin
            ok = 1'b0;
        end
        if (v[15:12] > 4'd5) begin
            ok = 1'b0;
        end
        if (v[23:20] > 4'd2) begin
            ok = 1'b0;
        end
        if ((v[23:20] == 4'd2) && (v[19:16] > 4'd3)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Subtracts one second with a ripple borrow through the six digits.
    function automatic logic [23:0] bcd_time_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = WRAP_DIGITS[i*4 +: 4];
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Strobe polarity is fixed at elaboration time.
    assign tick_act  = (TICK_POL != 0) ? tick : ~tick;
    assign preset_ok = bcd_time_valid(preset);
    assign count_dec = bcd_time_dec(count_q);

    // Next-state decode: control priority is reset > pause > tick in RUN,
    // and load > start in the stopped states.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        err_d    = err_q;
        done_d   = 1'b0;
`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
        preset_d = preset_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (pause) begin
                    state_d = ST_PAUSED;
                end else if (tick_act) begin
                    if (count_q == COUNT_ONE) begin
                        done_d = 1'b1;
`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
                        if (preset_q != COUNT_ZERO) begin
                            count_d = preset_q;
                        end else begin
                            count_d = COUNT_ZERO;
                            state_d = ST_DONE;
                        end
`else
                        count_d = COUNT_ZERO;
                        state_d = ST_DONE;
`endif
                    end else if (count_q != COUNT_ZERO) begin
                        count_d = count_dec;
                    end else begin
                        // A zero count cannot reach RUN; park in DONE rather than wrap.
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                if (load) begin
                    if (preset_ok) begin
                        count_d  = preset;
                        err_d    = 1'b0;
                        state_d  = ST_IDLE;
`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
                        preset_d = preset;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (start && !pause && (state_q != ST_DONE) &&
                             (count_q != COUNT_ZERO)) begin
                    state_d = ST_RUN;
                end
            end
        endcase
        running_d = (state_d == ST_RUN);
    end

    // State, count and registered status flags.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= COUNT_ZERO;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
            preset_q  <= COUNT_ZERO;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            running_q <= running_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
            preset_q  <= preset_d;
`endif
        end
    end

    assign sec0     = count_q[3:0];
    assign sec1     = count_q[7:4];
    assign sec2     = count_q[11:8];
    assign sec3     = count_q[15:12];
    assign sec4     = count_q[19:16];
    assign sec5     = count_q[23:20];
    assign running  = running_q;
    assign done     = done_q;
    assign load_err = err_q;

endmodule

// File: doc/hms_countdown.md
Name: hms_countdown

Overview:
- 24-hour HH:MM:SS BCD countdown timer; the down-counting counterpart of the team's six-digit up-counting time-of-day block.
- Loads a validated preset and decrements it once per `tick` strobe while running.
- Flags expiry at 00:00:00.
- Drives the same six-digit BCD bus (`sec0`..`sec5`) into the existing seven-segment display path.

Parameters:
- `TICK_POL`, default 1, meaning: level of `tick` that counts as a strobe (1 = active-high; 0 = active-low strobe).

Ports:
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst_n` input 1: synchronous, active-high reset (asserted when 1).
- `tick` input 1: one-`clk`-wide count strobe (e.g. 1 Hz from the prescaler).
- `load` input 1: load request for `preset`.
- `preset` input 24: BCD preset; [23:20]=hours tens, [19:16]=hours units, [15:12]=min tens, [11:8]=min units, [7:4]=sec tens, [3:0]=sec units.
- `start` input 1: start/resume request.
- `pause` input 1: pause request.
- `sec0` output 4: seconds units.
- `sec1` output 4: seconds tens.
- `sec2` output 4: minutes units.
- `sec3` output 4: minutes tens.
- `sec4` output 4: hours units.
- `sec5` output 4: hours tens.
- `running` output 1: high while state is RUN.
- `done` output 1: one-cycle expiry pulse.
- `load_err` output 1: sticky flag, last load rejected.

Behaviour:
- Reset (`rst_n`=1 at an edge): all digits 0, stored preset 0, state IDLE, `running`=0, `done`=0, `load_err`=0. Applies regardless of state, including mid-RUN.
- States and their decoding:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSED: counting suspended, value held.
  - DONE: expired, holding 00:00:00.
- Preset validity, all conditions required:
  - every digit ≤ 9;
  - sec tens ≤ 5 and min tens ≤ 5;
  - hours tens ≤ 2;
  - if hours tens = 2, hours units ≤ 3.
- `load` is honoured only in IDLE, PAUSED and DONE; it is ignored in RUN.
  - Valid preset: digits and stored preset take the `preset` value at the next edge, `load_err` clears, state goes to IDLE.
  - Invalid preset: digits and state unchanged, `load_err` set to 1.
- `start` in IDLE or PAUSED goes to RUN only if the count is nonzero. A zero count leaves the state unchanged. `start` in DONE or RUN has no effect.
- `pause` in RUN goes to PAUSED. If `start` and `pause` are asserted in the same cycle, `pause` has priority.
- `load` and `start` in the same cycle: the load is taken and the state goes to IDLE; `start` is ignored that cycle.
- `tick` is acted on only in RUN and is ignored in all other states.
- Decrement in RUN, on an edge where `tick` is active: the count drops by one second. Digits update at that edge (1-cycle latency).
- Borrow chain, each digit borrows from the next when it wraps:
  - `sec0` 0→9, borrow to `sec1`;
  - `sec1` 0→5, borrow to `sec2`;
  - `sec2` 0→9, borrow to `sec3`;
  - `sec3` 0→5, borrow to `sec4`;
  - `sec4` 0→9, borrow to `sec5`.
  - Examples: 10:00:00→09:59:59, 20:00:00→19:59:59.
- Expiry: on the tick that takes 00:00:01→00:00:00, state goes to DONE at the same edge.
  - `done`=1 for exactly the following cycle; `running`=0 from that cycle.
  - The count never wraps below 00:00:00.
- `running` is a registered decode of the RUN state.
- Digits never hold non-BCD values, in any state.

Optional Feature:
- Macro: `HMS_COUNTDOWN_AUTO_RELOAD_EN`.
- Defined: on the expiry tick, digits reload the stored preset at the same edge instead of showing 00:00:00. `done` still pulses for one cycle, the state stays RUN, and DONE is unreachable. If the stored preset is 00:00:00, the block enters DONE as in the undefined case.
- Undefined: behaviour exactly as in Behaviour.

Test Plan:
- Reset, then load preset 0x000005, start, apply 5 ticks → digits 00:00:04..00:00:00, `done` pulses once one cycle after the 5th tick, `running`=0, further ticks leave 00:00:00.
- Load 0x100000, start, 1 tick → 09:59:59.
- Load 0x235959, start, 1 tick → 23:59:58.
- Load 0x246000 → `load_err`=1 and digits unchanged. Then load 0x240000 → `load_err` stays 1. Then a valid load 0x000010 → `load_err`=0 and digits 00:00:10.
- Run from 00:00:10; pause and tick in the same cycle → no decrement, PAUSED. 3 ticks while paused → still 00:00:10. `start`+`pause` together → stays PAUSED. `start` → RUN, next tick → 00:00:09. `load` in RUN → ignored.
- Assert reset mid-run at 01:02:03 → next cycle all digits 0, IDLE. Then `start` → stays IDLE, `running`=0. With `HMS_COUNTDOWN_AUTO_RELOAD_EN`: preset 0x000002, start, 4 ticks → 01, 02, 01, 02 (each expiry tick reloads 00:00:02 directly), `done` pulses twice, `running` stays 1.
